// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage request and the pipeline-control response of the
// hazard scoreboard.
//   master : ID stage / bench side (drives the instruction fields, observes
//            the enables, bubble select, busy vector and watchdog flag)
//   slave  : the scoreboard itself
// Optional build macro: HAZARD_PERF_EN adds the stall_cycles / flush_cycles
// performance counters.
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int CW         = 3
);
    // ID-stage request
    logic                  issue_validD;
    logic [REG_ADDR_W-1:0] rs_addrD;
    logic [REG_ADDR_W-1:0] rt_addrD;
    logic                  uses_rsD;
    logic                  uses_rtD;
    logic                  dest_wrD;
    logic [REG_ADDR_W-1:0] dest_addrD;
    logic [CW-1:0]         lat_D;
    logic                  pc_src;
    logic                  jumpD;

    // Pipeline-control response
    logic                  pc_enable;
    logic                  instr_enable;
    logic                  control_mux;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  stall_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           flush_cycles;
`endif

    modport master (
        output issue_validD, rs_addrD, rt_addrD, uses_rsD, uses_rtD,
               dest_wrD, dest_addrD, lat_D, pc_src, jumpD,
        input  pc_enable, instr_enable, control_mux, busy_vec, stall_timeout
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_cycles
`endif
    );

    modport slave (
        input  issue_validD, rs_addrD, rt_addrD, uses_rsD, uses_rtD,
               dest_wrD, dest_addrD, lat_D, pc_src, jumpD,
        output pc_enable, instr_enable, control_mux, busy_vec, stall_timeout
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_cycles
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register latency scoreboard beside the ID stage. Each architectural
// register (except r0) has a countdown of cycles until its pending result is
// forwardable. An ID instruction reading a busy register stalls PC and IF/ID
// and injects a bubble into ID/EX; a taken branch or jump without a hazard
// flushes by injecting a bubble while letting the front end advance.
// A watchdog raises a sticky flag after STALL_LIMIT consecutive stall cycles.
//
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : hazard_scoreboard_if.slave (ID request in, control out)
//
// Optional build macro: HAZARD_PERF_EN adds saturating 32-bit counters of
// stall cycles and flush cycles on the interface.
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_REGS    = 32,
    parameter int MAX_LAT     = 7,
    parameter int STALL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_scoreboard_if.slave    bus
);
    localparam int CW    = $clog2(MAX_LAT + 1);
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    LAT_MAX   = CW'(MAX_LAT);
    localparam logic [RUN_W-1:0] RUN_ZERO  = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_LIMIT);

    logic [CW-1:0]       cnt_r [NUM_REGS];
    logic [RUN_W-1:0]    run_r;
    logic                timeout_r;

    logic                rs_busy_s;
    logic                rt_busy_s;
    logic                hazard_s;
    logic                flush_s;
    logic                issue_s;
    logic [CW-1:0]       lat_clamp_s;
    logic [RUN_W-1:0]    run_nxt_s;
    logic [NUM_REGS-1:0] busy_s;
    logic                pc_en_s;
    logic                instr_en_s;
    logic                ctrl_mux_s;

    // Hazard detection against the counters as they stand before this edge,
    // so a source equal to the destination sees the old entry.
    always_comb begin
        rs_busy_s = bus.uses_rsD && (cnt_r[bus.rs_addrD] != CNT_ZERO);
        rt_busy_s = bus.uses_rtD && (cnt_r[bus.rt_addrD] != CNT_ZERO);
        hazard_s  = bus.issue_validD && (rs_busy_s || rt_busy_s);
        flush_s   = bus.pc_src || bus.jumpD;
        issue_s   = bus.issue_validD && !hazard_s && bus.dest_wrD &&
                    (bus.dest_addrD != {REG_ADDR_W{1'b0}}) &&
                    (bus.lat_D != CNT_ZERO);
    end

    // Latency clamp: producers slower than MAX_LAT are tracked as MAX_LAT.
    always_comb begin
        if (bus.lat_D > LAT_MAX) begin
            lat_clamp_s = LAT_MAX;
        end else begin
            lat_clamp_s = bus.lat_D;
        end
    end

    // Pipeline control priority: stall beats flush beats normal flow.
    always_comb begin
        pc_en_s    = 1'b1;
        instr_en_s = 1'b1;
        ctrl_mux_s = 1'b1;
        if (hazard_s) begin
            pc_en_s    = 1'b0;
            instr_en_s = 1'b0;
            ctrl_mux_s = 1'b0;
        end else if (flush_s) begin
            ctrl_mux_s = 1'b0;
        end else begin
            ctrl_mux_s = 1'b1;
        end
    end

    // Busy vector straight from the counters; r0 is never busy.
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_s[r] = (cnt_r[r] != CNT_ZERO);
        end
    end

    // Countdown table: a new issue overwrites (write-after-write and same-cycle
    // decrement both resolve to the new latency); otherwise count down to 0.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!rst_n || (r == 0)) begin
                cnt_r[r] <= CNT_ZERO;
            end else if (issue_s && (bus.dest_addrD == REG_ADDR_W'(r))) begin
                cnt_r[r] <= lat_clamp_s;
            end else if (cnt_r[r] != CNT_ZERO) begin
                cnt_r[r] <= cnt_r[r] - CNT_ONE;
            end else begin
                cnt_r[r] <= cnt_r[r];
            end
        end
    end

    // Next value of the consecutive-stall run length, saturating at the limit.
    always_comb begin
        if (!hazard_s) begin
            run_nxt_s = RUN_ZERO;
        end else if (run_r == RUN_LIMIT) begin
            run_nxt_s = run_r;
        end else begin
            run_nxt_s = run_r + RUN_ONE;
        end
    end

    // Watchdog run counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_r     <= RUN_ZERO;
            timeout_r <= 1'b0;
        end else begin
            run_r     <= run_nxt_s;
            timeout_r <= timeout_r || (run_nxt_s == RUN_LIMIT);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating counters of stall cycles and flush-only cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end
            if (!hazard_s && flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_r;
    assign bus.flush_cycles = flush_cnt_r;
`endif

    assign bus.pc_enable     = pc_en_s;
    assign bus.instr_enable  = instr_en_s;
    assign bus.control_mux   = ctrl_mux_s;
    assign bus.busy_vec      = busy_s;
    assign bus.stall_timeout = timeout_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed scenarios followed by randomized ID traffic. The reference model
// tracks, per register, the absolute cycle at which its pending result becomes
// forwardable; a register is busy while the current cycle is before that.
// Built with MAX_LAT=6 so lat_D=7 exercises the clamp, and STALL_LIMIT=4.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int RAW         = 5;
    localparam int NR          = 32;
    localparam int MAX_LAT     = 6;
    localparam int STALL_LIMIT = 4;
    localparam int CW          = $clog2(MAX_LAT + 1);

    typedef struct {
        bit           valid;
        bit [RAW-1:0] rs;
        bit           urs;
        bit [RAW-1:0] rt;
        bit           urt;
        bit           dw;
        bit [RAW-1:0] dest;
        bit [CW-1:0]  lat;
        bit           pcs;
        bit           jmp;
    } instr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(RAW), .NUM_REGS(NR), .CW(CW)) sb_if ();

    hazard_scoreboard #(
        .REG_ADDR_W (RAW),
        .NUM_REGS   (NR),
        .MAX_LAT    (MAX_LAT),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sb_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     ready_at [NR];
    int     cyc = 0;
    int     run_len = 0;
    bit     timeout_m = 1'b0;
    longint stall_m = 0;
    longint flush_m = 0;

    // Last sampled DUT outputs
    bit          obs_pc, obs_ie, obs_cm, obs_to;
    logic [NR-1:0] obs_busy;
    logic [31:0] obs_stall;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit reg_busy(input int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    function automatic instr_t mk(input bit v, input bit [RAW-1:0] rs, input bit urs,
                                  input bit [RAW-1:0] rt, input bit urt, input bit dw,
                                  input bit [RAW-1:0] dest, input bit [CW-1:0] lat,
                                  input bit pcs, input bit jmp);
        instr_t i;
        i.valid = v;  i.rs = rs;   i.urs = urs; i.rt = rt;  i.urt = urt;
        i.dw = dw;    i.dest = dest; i.lat = lat; i.pcs = pcs; i.jmp = jmp;
        return i;
    endfunction

    function automatic instr_t idle();
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    endfunction

    function automatic instr_t rnd_instr();
        return mk(($urandom_range(0, 9) != 0), RAW'($urandom_range(0, 15)), 1'($urandom),
                  RAW'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  RAW'($urandom_range(0, 15)), CW'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
    endfunction

    task automatic apply(input instr_t i);
        sb_if.issue_validD = i.valid;
        sb_if.rs_addrD     = i.rs;
        sb_if.uses_rsD     = i.urs;
        sb_if.rt_addrD     = i.rt;
        sb_if.uses_rtD     = i.urt;
        sb_if.dest_wrD     = i.dw;
        sb_if.dest_addrD   = i.dest;
        sb_if.lat_D        = i.lat;
        sb_if.pc_src       = i.pcs;
        sb_if.jumpD        = i.jmp;
    endtask

    // One ID cycle: drive, compare against the model, then advance the model.
    task automatic step(input instr_t i);
        bit haz, flush, iss;
        logic [NR-1:0] exp_busy;
        int l;
        @(negedge clk);
        rst_n = 1'b1;
        apply(i);
        #1;
        haz   = i.valid && ((i.urs && reg_busy(int'(i.rs))) || (i.urt && reg_busy(int'(i.rt))));
        flush = i.pcs || i.jmp;
        for (int r = 0; r < NR; r++) exp_busy[r] = reg_busy(r);
        obs_pc   = sb_if.pc_enable;
        obs_ie   = sb_if.instr_enable;
        obs_cm   = sb_if.control_mux;
        obs_to   = sb_if.stall_timeout;
        obs_busy = sb_if.busy_vec;
        check_value("pc_enable", 64'(obs_pc), 64'(!haz));
        check_value("instr_enable", 64'(obs_ie), 64'(!haz));
        check_value("control_mux", 64'(obs_cm), 64'(!haz && !flush));
        check_value("busy_vec", 64'(obs_busy), 64'(exp_busy));
        check_value("stall_timeout", 64'(obs_to), 64'(timeout_m));
`ifdef HAZARD_PERF_EN
        obs_stall = sb_if.stall_cycles;
        check_value("stall_cycles", 64'(obs_stall), 64'(stall_m));
        check_value("flush_cycles", 64'(sb_if.flush_cycles), 64'(flush_m));
`else
        obs_stall = 32'd0;
`endif
        @(posedge clk);
        iss = i.valid && !haz && i.dw && (i.dest != 0) && (i.lat != 0);
        if (iss) begin
            l = (int'(i.lat) > MAX_LAT) ? MAX_LAT : int'(i.lat);
            ready_at[i.dest] = cyc + 1 + l;
        end
        if (haz) run_len = (run_len < STALL_LIMIT) ? run_len + 1 : run_len;
        else     run_len = 0;
        if (run_len >= STALL_LIMIT) timeout_m = 1'b1;
        if (haz) stall_m++;
        if (!haz && flush) flush_m++;
        cyc++;
    endtask

    // Hold reset for two edges with random inputs; the next step releases it.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply(rnd_instr());
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        run_len   = 0;
        timeout_m = 1'b0;
        stall_m   = 0;
        flush_m   = 0;
    endtask

    // Repeat a held instruction until it stops stalling (bounded).
    task automatic count_stalls(input instr_t i, output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(i);
            if (obs_pc) break;
            n++;
        end
    endtask

    int n;

    initial begin
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        apply(idle());

        // Reset state
        do_reset();
        step(idle());
        check_value("rst_busy", 64'(obs_busy), 64'd0);
        check_value("rst_pc", 64'(obs_pc), 64'd1);
        check_value("rst_cm", 64'(obs_cm), 64'd1);
        check_value("rst_timeout", 64'(obs_to), 64'd0);

        // Load-use: one stall cycle
        step(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0));
        step(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        check_value("lu_stall_pc", 64'(obs_pc), 64'd0);
        check_value("lu_stall_cm", 64'(obs_cm), 64'd0);
        check_value("lu_busy8", 64'(obs_busy[8]), 64'd1);
        step(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        check_value("lu_release_pc", 64'(obs_pc), 64'd1);
        check_value("lu_busy8_clear", 64'(obs_busy[8]), 64'd0);

        // Multi-cycle producer, dependent on rt plus an independent rs
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 5, 4, 0, 0));
        count_stalls(mk(1, 6, 1, 5, 1, 0, 0, 0, 0, 0), n);
        check_value("mc_stalls", 64'(n), 64'd4);

        // Priority: hazard beats branch, then plain flush
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 3, 2, 0, 0));
        step(mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0));
        check_value("prio_pc", 64'(obs_pc), 64'd0);
        check_value("prio_ie", 64'(obs_ie), 64'd0);
        check_value("prio_cm", 64'(obs_cm), 64'd0);
        step(idle());
        step(mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0));
        check_value("flush_pc", 64'(obs_pc), 64'd1);
        check_value("flush_cm", 64'(obs_cm), 64'd0);
        step(idle());
        check_value("after_flush_cm", 64'(obs_cm), 64'd1);

        // dest = r0 leaves no entry
        step(mk(1, 0, 0, 0, 0, 1, 0, 5, 0, 0));
        step(idle());
        check_value("r0_busy", 64'(obs_busy), 64'd0);

        // Latency clamp to MAX_LAT
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 10, 7, 0, 0));
        count_stalls(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0), n);
        check_value("clamp_stalls", 64'(n), 64'd6);

        // Write-after-write overwrites
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 9, 6, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0));
        count_stalls(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0), n);
        check_value("waw_stalls", 64'(n), 64'd1);

        // Re-issue while decrementing: new value wins
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 11, 3, 0, 0));
        step(mk(1, 0, 0, 0, 0, 1, 11, 5, 0, 0));
        count_stalls(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0), n);
        check_value("reissue_stalls", 64'(n), 64'd5);

        // Source equal to destination checks the old entry
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 13, 2, 0, 0));
        step(mk(1, 13, 1, 0, 0, 1, 13, 3, 0, 0));
        check_value("src_eq_dest_stall", 64'(obs_pc), 64'd0);

        // Watchdog
        do_reset();
        step(mk(1, 0, 0, 0, 0, 1, 12, 7, 0, 0));
        for (int k = 0; k < 6; k++) begin
            step(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0));
            check_value("wd_stall", 64'(obs_pc), 64'd0);
            check_value("wd_timeout", 64'(obs_to), 64'(k >= 4));
        end
        step(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0));
        check_value("wd_release", 64'(obs_pc), 64'd1);
        step(idle());
        check_value("wd_sticky", 64'(obs_to), 64'd1);
`ifdef HAZARD_PERF_EN
        check_value("wd_perf_stalls", 64'(obs_stall), 64'd6);
`endif
        do_reset();
        step(idle());
        check_value("wd_cleared", 64'(obs_to), 64'd0);

        // Reset in the middle of a stall
        step(mk(1, 0, 0, 0, 0, 1, 14, 6, 0, 0));
        step(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0));
        do_reset();
        step(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0));
        check_value("midstall_reset_pc", 64'(obs_pc), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ((k % 60) == 59) do_reset();
            else step(rnd_instr());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
